// File: rtl/rxll_frame_fifo_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : rxll_frame_fifo_if
//  Description : Write/read handshake bundle for rxll_frame_fifo.
//                master = producer/consumer side, slave = FIFO side.
//  Signals     : wr_di/wr_sof/wr_eof/wr_en      write request + sideband
//                wr_abort                       only with RXLL_FIFO_ABORT_EN
//                wr_full/wr_almost_full/wr_count/wr_err   write status
//                rd_en                          pop request
//                rd_do/rd_sof/rd_eof            FWFT head word
//                rd_empty/rd_almost_empty/rd_count/rd_err read status
//                frame_count/rd_eof_rdy         complete-frame tracking
//  Macro       : RXLL_FIFO_ABORT_EN adds wr_abort
//  Revision    : 1.0  initial release
// ============================================================================
interface rxll_frame_fifo_if #(
    parameter int C_DATA_WIDTH = 32,
    parameter int C_DEPTH_LOG2 = 9
);
    logic [C_DATA_WIDTH-1:0] wr_di;
    logic                    wr_sof;
    logic                    wr_eof;
    logic                    wr_en;
    logic                    wr_full;
    logic                    wr_almost_full;
    logic [C_DEPTH_LOG2:0]   wr_count;
    logic                    wr_err;
    logic                    rd_en;
    logic [C_DATA_WIDTH-1:0] rd_do;
    logic                    rd_sof;
    logic                    rd_eof;
    logic                    rd_empty;
    logic                    rd_almost_empty;
    logic [C_DEPTH_LOG2:0]   rd_count;
    logic                    rd_err;
    logic [C_DEPTH_LOG2:0]   frame_count;
    logic                    rd_eof_rdy;

`ifdef RXLL_FIFO_ABORT_EN
    logic                    wr_abort;

    modport master (
        output wr_di, wr_sof, wr_eof, wr_en, wr_abort, rd_en,
        input  wr_full, wr_almost_full, wr_count, wr_err,
               rd_do, rd_sof, rd_eof, rd_empty, rd_almost_empty, rd_count, rd_err,
               frame_count, rd_eof_rdy
    );
    modport slave (
        input  wr_di, wr_sof, wr_eof, wr_en, wr_abort, rd_en,
        output wr_full, wr_almost_full, wr_count, wr_err,
               rd_do, rd_sof, rd_eof, rd_empty, rd_almost_empty, rd_count, rd_err,
               frame_count, rd_eof_rdy
    );
`else
    modport master (
        output wr_di, wr_sof, wr_eof, wr_en, rd_en,
        input  wr_full, wr_almost_full, wr_count, wr_err,
               rd_do, rd_sof, rd_eof, rd_empty, rd_almost_empty, rd_count, rd_err,
               frame_count, rd_eof_rdy
    );
    modport slave (
        input  wr_di, wr_sof, wr_eof, wr_en, rd_en,
        output wr_full, wr_almost_full, wr_count, wr_err,
               rd_do, rd_sof, rd_eof, rd_empty, rd_almost_empty, rd_count, rd_err,
               frame_count, rd_eof_rdy
    );
`endif
endinterface
`default_nettype wire

// File: rtl/rxll_frame_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : rxll_frame_fifo
//  Description : Single-clock FWFT receive link-layer FIFO. Each entry holds
//                data plus SOF/EOF; counts complete frames, flags thresholds
//                and reports rejected accesses / framing errors.
//  Ports       : clk   sole clock
//                rst   asynchronous active-high reset
//                bus   rxll_frame_fifo_if.slave (write side, read side,
//                      status and frame tracking)
//  Macro       : RXLL_FIFO_ABORT_EN - store-and-forward on frame boundaries
//                with wr_abort; undefined = cut-through.
//  Revision    : 1.0  initial release
// ============================================================================
module rxll_frame_fifo #(
    parameter int C_DATA_WIDTH    = 32,
    parameter int C_DEPTH_LOG2    = 9,
    parameter int C_AFULL_THRESH  = 256,
    parameter int C_AEMPTY_THRESH = 128
) (
    input  wire logic        clk,
    input  wire logic        rst,
    rxll_frame_fifo_if.slave bus
);

    localparam int                  c_depth   = 2 ** C_DEPTH_LOG2;
    localparam int                  c_mem_w   = C_DATA_WIDTH + 2;
    localparam logic [C_DEPTH_LOG2:0] c_ptr_one = {{C_DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [C_DEPTH_LOG2:0] c_afull   = C_AFULL_THRESH[C_DEPTH_LOG2:0];
    localparam logic [C_DEPTH_LOG2:0] c_aempty  = C_AEMPTY_THRESH[C_DEPTH_LOG2:0];

    // Write framing states
    localparam logic [0:0] W_IDLE  = 1'b0;
    localparam logic [0:0] W_FRAME = 1'b1;

    // Entry layout: {sof, eof, data}
    logic [c_mem_w-1:0]      r_mem [c_depth];

    logic [C_DEPTH_LOG2:0]   r_wr_ptr;
    logic [C_DEPTH_LOG2:0]   r_rd_ptr;
    logic [C_DEPTH_LOG2:0]   r_frame_count;
    logic [0:0]              r_wstate;
    logic                    r_wr_err;
    logic                    r_rd_err;

    logic [C_DEPTH_LOG2:0]   w_commit_ptr;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_abort;
    logic                    w_wr_acc;
    logic                    w_rd_acc;
    logic [c_mem_w-1:0]      w_head;
    logic [C_DEPTH_LOG2:0]   w_wr_count;
    logic [C_DEPTH_LOG2:0]   w_rd_count;

    // Pointers carry one extra wrap bit: full when only the wrap bits differ.
    assign w_full  = (r_wr_ptr[C_DEPTH_LOG2] != r_rd_ptr[C_DEPTH_LOG2]) &&
                     (r_wr_ptr[C_DEPTH_LOG2-1:0] == r_rd_ptr[C_DEPTH_LOG2-1:0]);
    // The reader only ever sees entries up to the commit point.
    assign w_empty = (r_rd_ptr == w_commit_ptr);

    // An effective abort swallows any concurrent write without flagging it.
    assign w_wr_acc = bus.wr_en && !w_full && !w_abort;
    assign w_rd_acc = bus.rd_en && !w_empty;

    assign w_head     = r_mem[r_rd_ptr[C_DEPTH_LOG2-1:0]];
    assign w_wr_count = r_wr_ptr - r_rd_ptr;
    assign w_rd_count = w_commit_ptr - r_rd_ptr;

`ifdef RXLL_FIFO_ABORT_EN
    logic [C_DEPTH_LOG2:0]   r_commit_ptr;
    logic [C_DEPTH_LOG2:0]   r_save_ptr;

    // Abort only means something while a frame is open.
    assign w_abort      = bus.wr_abort && (r_wstate == W_FRAME);
    assign w_commit_ptr = r_commit_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_commit_ptr <= '0;
            r_save_ptr   <= '0;
        end else begin
            if (w_wr_acc && bus.wr_sof)
                r_save_ptr <= r_wr_ptr;
            // Commit point moves past the EOF word so the whole frame
            // becomes readable at once.
            if (w_wr_acc && bus.wr_eof)
                r_commit_ptr <= r_wr_ptr + c_ptr_one;
        end
    end
`else
    assign w_abort      = 1'b0;
    assign w_commit_ptr = r_wr_ptr;
`endif

    // Storage array: no reset, contents are only visible through pointers.
    always_ff @(posedge clk) begin
        if (w_wr_acc)
            r_mem[r_wr_ptr[C_DEPTH_LOG2-1:0]] <= {bus.wr_sof, bus.wr_eof, bus.wr_di};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_frame_count <= '0;
            r_wstate      <= W_IDLE;
            r_wr_err      <= 1'b0;
            r_rd_err      <= 1'b0;
        end else begin
            r_wr_err <= (bus.wr_en && w_full && !w_abort) ||
                        (w_wr_acc && bus.wr_sof && (r_wstate == W_FRAME));
            r_rd_err <= bus.rd_en && w_empty;

            if (w_rd_acc)
                r_rd_ptr <= r_rd_ptr + c_ptr_one;

`ifdef RXLL_FIFO_ABORT_EN
            if (w_abort)
                r_wr_ptr <= r_save_ptr;
            else if (w_wr_acc)
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
`else
            if (w_wr_acc)
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
`endif

            case ({w_wr_acc && bus.wr_eof, w_rd_acc && w_head[C_DATA_WIDTH]})
                2'b10:   r_frame_count <= r_frame_count + c_ptr_one;
                2'b01:   r_frame_count <= r_frame_count - c_ptr_one;
                default: r_frame_count <= r_frame_count;
            endcase

            // A SOF seen inside a frame is stored and the frame carries on.
            if (w_abort)
                r_wstate <= W_IDLE;
            else if (w_wr_acc) begin
                if (bus.wr_eof)
                    r_wstate <= W_IDLE;
                else if (bus.wr_sof)
                    r_wstate <= W_FRAME;
            end
        end
    end

    assign bus.wr_full         = w_full;
    assign bus.wr_almost_full  = (w_wr_count >= c_afull);
    assign bus.wr_count        = w_wr_count;
    assign bus.wr_err          = r_wr_err;
    assign bus.rd_empty        = w_empty;
    assign bus.rd_almost_empty = (w_rd_count <= c_aempty);
    assign bus.rd_count        = w_rd_count;
    assign bus.rd_err          = r_rd_err;
    assign bus.frame_count     = r_frame_count;
    assign bus.rd_eof_rdy      = (r_frame_count != '0);

    // Head is masked while empty so stale array contents never leak out.
    assign bus.rd_do  = w_empty ? '0   : w_head[C_DATA_WIDTH-1:0];
    assign bus.rd_eof = w_empty ? 1'b0 : w_head[C_DATA_WIDTH];
    assign bus.rd_sof = w_empty ? 1'b0 : w_head[C_DATA_WIDTH+1];

endmodule
`default_nettype wire

// File: tb/tb_rxll_frame_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_rxll_frame_fifo
//  Description : Randomised scoreboard bench for rxll_frame_fifo. A queue
//                model tracks committed/uncommitted words; a monitor pops
//                expected words whenever the DUT delivers a read.
//  Macro       : RXLL_FIFO_ABORT_EN enables the abort sequences
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rxll_frame_fifo;

    localparam int DW     = 32;
    localparam int DL2    = 9;
    localparam int DEPTH  = 512;
    localparam int AFULL  = 256;
    localparam int AEMPTY = 128;

    typedef logic [DW+1:0] word_t;   // {sof, eof, data}

    logic clk = 1'b0;
    logic rst = 1'b1;

    rxll_frame_fifo_if #(.C_DATA_WIDTH(DW), .C_DEPTH_LOG2(DL2)) bus ();

    rxll_frame_fifo #(
        .C_DATA_WIDTH   (DW),
        .C_DEPTH_LOG2   (DL2),
        .C_AFULL_THRESH (AFULL),
        .C_AEMPTY_THRESH(AEMPTY)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference model: readable words, words written but not yet committed.
    word_t commit_q[$];
    word_t pend_q[$];
    word_t exp_q[$];
    int    save_len;
    bit    in_frame;
    bit    exp_wr_err;
    bit    exp_rd_err;
    int    n_checks;
    int    n_fail;
    word_t mon_w;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int eof_total();
        int n = 0;
        foreach (commit_q[i]) if (commit_q[i][DW]) n++;
        foreach (pend_q[i])   if (pend_q[i][DW])   n++;
        return n;
    endfunction

    function automatic word_t mk(input bit s, input bit e, input logic [DW-1:0] d);
        return {s, e, d};
    endfunction

    function automatic word_t rnd_word();
        return {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), DW'($urandom)};
    endfunction

    task automatic check_state();
        int total = commit_q.size() + pend_q.size();
        int rdbl  = commit_q.size();
        int fc    = eof_total();
        chk("rd_empty",        bus.rd_empty,        rdbl == 0);
        chk("wr_full",         bus.wr_full,         total == DEPTH);
        chk("wr_count",        bus.wr_count,        total);
        chk("rd_count",        bus.rd_count,        rdbl);
        chk("frame_count",     bus.frame_count,     fc);
        chk("rd_eof_rdy",      bus.rd_eof_rdy,      fc != 0);
        chk("wr_almost_full",  bus.wr_almost_full,  total >= AFULL);
        chk("rd_almost_empty", bus.rd_almost_empty, rdbl <= AEMPTY);
        chk("wr_err",          bus.wr_err,          exp_wr_err);
        chk("rd_err",          bus.rd_err,          exp_rd_err);
        if (rdbl == 0)
            chk("rd_head_when_empty", {bus.rd_sof, bus.rd_eof, bus.rd_do}, 0);
    endtask

    // One clock: check state left by the previous edge, then drive new inputs
    // and advance the model by what the coming edge should do.
    task automatic step(input bit we, input word_t w, input bit re, input bit ab);
        bit full, empty, abort_eff, wa, ra;
        @(negedge clk);
        check_state();
        bus.wr_en  = we;
        bus.wr_di  = w[DW-1:0];
        bus.wr_eof = w[DW];
        bus.wr_sof = w[DW+1];
        bus.rd_en  = re;
`ifdef RXLL_FIFO_ABORT_EN
        bus.wr_abort = ab;
        abort_eff    = ab && in_frame;
`else
        abort_eff    = 1'b0;
        if (ab) abort_eff = 1'b0;
`endif
        full  = (commit_q.size() + pend_q.size()) == DEPTH;
        empty = commit_q.size() == 0;
        wa    = we && !full && !abort_eff;
        ra    = re && !empty;
        exp_wr_err = (we && full && !abort_eff) || (wa && w[DW+1] && in_frame);
        exp_rd_err = re && empty;
        if (ra) exp_q.push_back(commit_q.pop_front());
        if (abort_eff) begin
            while (pend_q.size() > save_len) void'(pend_q.pop_back());
            in_frame = 1'b0;
        end
        if (wa) begin
`ifdef RXLL_FIFO_ABORT_EN
            if (w[DW+1]) save_len = pend_q.size();
            pend_q.push_back(w);
            if (w[DW])
                while (pend_q.size() > 0) commit_q.push_back(pend_q.pop_front());
`else
            commit_q.push_back(w);
`endif
            if (w[DW])        in_frame = 1'b0;
            else if (w[DW+1]) in_frame = 1'b1;
        end
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0);
    endtask

    // Close any open frame, then read out everything readable.
    task automatic drain_all();
        step(1'b1, mk(1'b0, 1'b1, 32'hEE), 1'b0, 1'b0);
        while (commit_q.size() > 0) step(1'b0, '0, 1'b1, 1'b0);
        idle();
    endtask

    task automatic check_reset_values();
        chk("rst_rd_empty",        bus.rd_empty,        1);
        chk("rst_wr_full",         bus.wr_full,         0);
        chk("rst_wr_almost_full",  bus.wr_almost_full,  0);
        chk("rst_rd_almost_empty", bus.rd_almost_empty, 1);
        chk("rst_wr_err",          bus.wr_err,          0);
        chk("rst_rd_err",          bus.rd_err,          0);
        chk("rst_rd_eof_rdy",      bus.rd_eof_rdy,      0);
        chk("rst_frame_count",     bus.frame_count,     0);
        chk("rst_wr_count",        bus.wr_count,        0);
        chk("rst_head",            {bus.rd_sof, bus.rd_eof, bus.rd_do}, 0);
    endtask

    task automatic clear_model();
        commit_q.delete();
        pend_q.delete();
        exp_q.delete();
        save_len   = 0;
        in_frame   = 1'b0;
        exp_wr_err = 1'b0;
        exp_rd_err = 1'b0;
    endtask

    task automatic set_idle_inputs();
        bus.wr_en  = 1'b0;
        bus.wr_di  = '0;
        bus.wr_sof = 1'b0;
        bus.wr_eof = 1'b0;
        bus.rd_en  = 1'b0;
`ifdef RXLL_FIFO_ABORT_EN
        bus.wr_abort = 1'b0;
`endif
    endtask

    // Monitor: whenever a read will be accepted at the coming edge, the head
    // word must be the oldest outstanding expected word.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst && bus.rd_en && !bus.rd_empty) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rd_word: got 0x%0h expected no readable word at %0t",
                             {bus.rd_sof, bus.rd_eof, bus.rd_do}, $time);
                end else begin
                    mon_w = exp_q.pop_front();
                    chk("rd_word", {bus.rd_sof, bus.rd_eof, bus.rd_do}, mon_w);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        clear_model();
        set_idle_inputs();
        #3;
        check_reset_values();
        @(negedge clk);
        #2 rst = 1'b0;

        // Three-word frame then pop it
        step(1'b1, mk(1'b1, 1'b0, 32'hA0), 1'b0, 1'b0);
        step(1'b1, mk(1'b0, 1'b0, 32'hA1), 1'b0, 1'b0);
        step(1'b1, mk(1'b0, 1'b1, 32'hA2), 1'b0, 1'b0);
        idle();
        chk("t1_frame_count", bus.frame_count, 1);
        chk("t1_wr_count",    bus.wr_count,    3);
        chk("t1_head",        {bus.rd_sof, bus.rd_do}, {1'b1, 32'hA0});
        repeat (3) step(1'b0, '0, 1'b1, 1'b0);
        idle();
        chk("t1_empty", bus.rd_empty, 1);

        // Fill to depth with single-word frames, overflow, drain
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, mk(1'b1, 1'b1, 32'h1000 + i), 1'b0, 1'b0);
        step(1'b1, mk(1'b1, 1'b1, 32'hDEAD), 1'b0, 1'b0);
        idle();
        chk("t2_full_count", bus.wr_count, DEPTH);
        chk("t2_frames_at_depth", bus.frame_count, DEPTH);
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0);
        idle();

        // Simultaneous read+write at full and at empty
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, mk(1'b1, 1'b1, 32'h2000 + i), 1'b0, 1'b0);
        step(1'b1, mk(1'b1, 1'b1, 32'hBEEF), 1'b1, 1'b0);
        idle();
        chk("t3_full_rdwr_count", bus.wr_count, DEPTH - 1);
        while (commit_q.size() > 0) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, mk(1'b1, 1'b1, 32'h3000), 1'b1, 1'b0);
        idle();
        chk("t3_empty_rdwr_count", bus.rd_count, 1);

        // Single-word frame written while the previous single-word frame is read
        step(1'b1, mk(1'b1, 1'b1, 32'h3001), 1'b1, 1'b0);
        idle();
        chk("t4_frame_count_same", bus.frame_count, 1);
        step(1'b0, '0, 1'b1, 1'b0);

        // Mixed random traffic alternating between fill- and drain-biased
        for (int ph = 0; ph < 6; ph++) begin
            for (int i = 0; i < 250; i++) begin
                bit we, re, ab;
                we = (ph % 2 == 0) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 3);
                re = (ph % 2 == 0) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 8);
                ab = ($urandom_range(0, 19) == 0);
                step(we, rnd_word(), re, ab);
            end
        end

`ifdef RXLL_FIFO_ABORT_EN
        // Aborted partial frame never becomes readable
        drain_all();
        step(1'b1, mk(1'b1, 1'b0, 32'hB0), 1'b0, 1'b0);
        step(1'b1, mk(1'b0, 1'b0, 32'hB1), 1'b0, 1'b0);
        step(1'b1, mk(1'b0, 1'b0, 32'hB2), 1'b0, 1'b0);
        step(1'b1, mk(1'b0, 1'b0, 32'hB3), 1'b0, 1'b1);
        idle();
        chk("t5_abort_wr_count", bus.wr_count, 0);
        chk("t5_abort_empty",    bus.rd_empty, 1);
        step(1'b1, mk(1'b1, 1'b0, 32'hC0), 1'b0, 1'b0);
        step(1'b1, mk(1'b0, 1'b1, 32'hC1), 1'b0, 1'b0);
        idle();
        chk("t5_head_after_eof", bus.rd_do, 32'hC0);
`endif

        // Asynchronous reset with 40 entries and an open frame
        drain_all();
        step(1'b1, mk(1'b1, 1'b0, 32'h4000), 1'b0, 1'b0);
        for (int i = 1; i < 40; i++)
            step(1'b1, mk(1'b0, 1'b0, 32'h4000 + i), 1'b0, 1'b0);
        idle();
        chk("t6_pre_reset_count", bus.wr_count, 40);
        #3 rst = 1'b1;
        #1;
        check_reset_values();
        clear_model();
        set_idle_inputs();
        @(negedge clk);
        #2 rst = 1'b0;

        // Recovery traffic after reset
        for (int i = 0; i < 60; i++)
            step($urandom_range(0, 1) == 1, rnd_word(), $urandom_range(0, 1) == 1, 1'b0);
        idle();
        idle();
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
